// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Each operation takes one radix-2 step per clock, so latency is fixed:
// busy for DATA_WIDTH cycles, then done pulses for one cycle with Result.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous, active-high reset
//   start     request a new operation (accepted only when not busy)
//   flush     abandon the current operation (beats start)
//   MulDivOp  RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   SrcA      rs1 operand (multiplicand / dividend)
//   SrcB      rs2 operand (multiplier / divisor)
//   busy      high while an operation is in progress
//   done      one-cycle pulse when Result becomes valid
//   Result    result, held until the next accepted operation completes
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            MulDivOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_next;
  logic [2:0]      op;
  logic [W-1:0]    addend;
  logic [2*W-1:0]  acc, acc_next;
  logic [CW-1:0]   count;
  logic            neg_a, neg_x, b_zero;
  logic            accept, last_step;
  logic            a_signed, b_signed, a_neg_in, b_neg_in;
  logic [W-1:0]    a_mag_in, b_mag_in;
  logic [W:0]      mul_sum, div_shift, div_diff;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    quo, rem, final_value;

  assign last_step = (count == CW'(W - 1));

  // Operand signedness from funct3; A is unsigned only for MULHU/DIVU/REMU,
  // B is signed only for MUL/MULH/DIV/REM.
  always_comb begin
    a_signed = ~(MulDivOp[0] & (MulDivOp[1] | MulDivOp[2]));
    b_signed = MulDivOp[2] ? ~MulDivOp[0] : ~MulDivOp[1];
    a_neg_in = a_signed & SrcA[W-1];
    b_neg_in = b_signed & SrcB[W-1];
    a_mag_in = a_neg_in ? -SrcA : SrcA;
    b_mag_in = b_neg_in ? -SrcB : SrcB;
  end

  // acc holds {high, low} of the product while multiplying and
  // {remainder, quotient} while dividing; addend is the multiplicand
  // or the divisor magnitude respectively.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? addend : {W{1'b0}})};
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, addend};
    acc_next  = {mul_sum, acc[W-1:1]};
    if (op[2]) begin
      if (div_diff[W])
        acc_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
      else
        acc_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
    end
  end

  // Sign fix-up of the final step. A zero divisor naturally leaves the
  // dividend in the remainder, but the quotient must bypass sign fix-up.
  always_comb begin
    prod        = neg_x ? -acc_next : acc_next;
    quo         = acc_next[W-1:0];
    rem         = acc_next[2*W-1:W];
    final_value = prod[2*W-1:W];
    case (op)
      3'b000:         final_value = prod[W-1:0];
      3'b100, 3'b101: final_value = b_zero ? {W{1'b1}} : (neg_x ? -quo : quo);
      3'b110, 3'b111: final_value = neg_a ? -rem : rem;
      default:        final_value = prod[2*W-1:W];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start && !flush) begin
          accept     = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (flush)          state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= 3'b000;
      addend <= '0;
      acc    <= '0;
      count  <= '0;
      neg_a  <= 1'b0;
      neg_x  <= 1'b0;
      b_zero <= 1'b0;
      Result <= '0;
    end else if (accept) begin
      op     <= MulDivOp;
      addend <= MulDivOp[2] ? b_mag_in : a_mag_in;
      acc    <= {{W{1'b0}}, (MulDivOp[2] ? a_mag_in : b_mag_in)};
      count  <= '0;
      neg_a  <= a_neg_in;
      neg_x  <= a_neg_in ^ b_neg_in;
      b_zero <= (SrcB == '0);
    end else if (state == CALC && !flush) begin
      acc   <= acc_next;
      count <= count + 1'b1;
      if (last_step) Result <= final_value;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (DATA_WIDTH = 32).
// Expected results are pushed to a scoreboard when an operation is issued
// and popped by a monitor whenever the unit raises done.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   MulDivOp;
  logic [W-1:0] SrcA, SrcB;
  logic         busy, done;
  logic [W-1:0] Result;

  typedef struct {
    string        tag;
    logic [W-1:0] value;
  } sb_entry_t;

  sb_entry_t    scoreboard[$];
  int           checkCount = 0;
  int           passCount  = 0;
  logic [W-1:0] lastResult = '0;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .MulDivOp(MulDivOp), .SrcA(SrcA), .SrcB(SrcB),
    .busy(busy), .done(done), .Result(Result)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Reference model built on native 64-bit arithmetic.
  function automatic logic [W-1:0] modelResult(input logic [2:0] op,
                                               input logic [W-1:0] a, b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'b000: begin sp = sa * sb; return sp[31:0]; end
      3'b001: begin sp = sa * sb; return sp[63:32]; end
      3'b010: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'b011: begin up = ua * ub; return up[63:32]; end
      3'b100: begin
        if (b == '0) return '1;
        if (a == 32'h8000_0000 && b == '1) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'b101: return (b == '0) ? '1 : a / b;
      3'b110: begin
        if (b == '0) return a;
        if (a == 32'h8000_0000 && b == '1) return '0;
        return $signed(a) % $signed(b);
      end
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  // Waits for an idle unit, then issues one operation across one clock edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, b,
                               input string tag, input logic [W-1:0] expected,
                               input bit expectDone);
    int guard = 0;
    sb_entry_t e;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) checkOutput("start_timeout", W'(busy), '0);
    MulDivOp = op;
    SrcA     = a;
    SrcB     = b;
    start    = 1'b1;
    if (expectDone) begin
      e.tag = tag;
      e.value = expected;
      scoreboard.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
    SrcA = $urandom;
    SrcB = $urandom;
  endtask

  // Counts sampling points from the start edge until done is seen.
  task automatic waitForDone(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 100);
    if (!done) checkOutput("done_timeout", W'(done), W'(1));
  endtask

  task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, b,
                       input logic [W-1:0] expected, input string tag);
    int lat;
    applyStimulus(op, a, b, tag, expected, 1'b1);
    waitForDone(lat);
    checkOutput({tag, "_latency"}, W'(lat), W'(LAT));
    lastResult = expected;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (scoreboard.size() == 0) begin
        checkOutput("spurious_done", W'(done), '0);
      end else begin
        sb_entry_t e;
        e = scoreboard.pop_front();
        checkOutput(e.tag, Result, e.value);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busyCount, doneAt, lat;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;
    sb_entry_t e;

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    MulDivOp = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", W'(busy), '0);
    checkOutput("reset_done", W'(done), '0);
    checkOutput("reset_result", Result, '0);

    // Exact cycle profile of a first operation.
    applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD, "mul_7_m3", 32'hFFFF_FFEB, 1'b1);
    busyCount = 0;
    doneAt = 0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (busy) busyCount++;
      if (done && doneAt == 0) doneAt = k;
      if (k == LAT + 1) begin
        checkOutput("idle_after_done", {30'b0, busy, done}, '0);
        checkOutput("result_held", Result, 32'hFFFF_FFEB);
      end
    end
    checkOutput("busy_cycles", W'(busyCount), W'(W));
    checkOutput("done_cycle", W'(doneAt), W'(LAT));

    runOp(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");
    runOp(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    runOp(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_max");
    runOp(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
    runOp(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
    runOp(3'b101, 32'd100, 32'd7, 32'd14, "divu_100_7");
    runOp(3'b111, 32'd100, 32'd7, 32'd2, "remu_100_7");
    runOp(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by_zero");
    runOp(3'b111, 32'd5, 32'd0, 32'd5, "remu_by_zero");
    runOp(3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, "div_neg_by_zero");
    runOp(3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, "rem_neg_by_zero");
    runOp(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
    runOp(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_overflow");

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i == 3) ? '0 : ($urandom >> $urandom_range(0, 28));
      runOp(rop, ra, rb, modelResult(rop, ra, rb), $sformatf("rand%0d_op%0d", i, rop));
    end

    // A start pulse ten cycles into an operation must be ignored.
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_start_ignored",
                  32'hFFFF_FFFE, 1'b1);
    repeat (10) @(negedge clk);
    MulDivOp = 3'b000; SrcA = 32'd1; SrcB = 32'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitForDone(lat);
    checkOutput("ignored_start_latency", W'(lat), W'(LAT - 10));
    lastResult = 32'hFFFF_FFFE;

    // Back-to-back: start held during the DONE cycle is accepted.
    applyStimulus(3'b101, 32'd1000, 32'd10, "b2b_first", 32'd100, 1'b1);
    waitForDone(lat);
    MulDivOp = 3'b000; SrcA = 32'd6; SrcB = 32'd9; start = 1'b1;
    e.tag = "b2b_second";
    e.value = 32'd54;
    scoreboard.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    waitForDone(lat);
    checkOutput("b2b_latency", W'(lat), W'(LAT));
    lastResult = 32'd54;

    // Flush at cycle 5: back to idle, no done, Result untouched.
    applyStimulus(3'b101, 32'd100, 32'd7, "flushed", '0, 1'b0);
    repeat (4) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", W'(busy), '0);
    checkOutput("flush_done", W'(done), '0);
    checkOutput("flush_result", Result, lastResult);
    repeat (40) @(negedge clk);

    // flush beats start when both arrive while idle.
    start = 1'b1; flush = 1'b1; MulDivOp = 3'b000;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_beats_start", W'(busy), '0);
    repeat (40) @(negedge clk);

    // Reset in the middle of a divide.
    applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, "reset_mid_div", '0, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", W'(busy), '0);
    checkOutput("midrst_done", W'(done), '0);
    checkOutput("midrst_result", Result, '0);
    runOp(3'b000, 32'd3, 32'd4, 32'd12, "mul_after_reset");

    repeat (40) @(negedge clk);
    checkOutput("scoreboard_empty", W'(scoreboard.size()), '0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
